// File: rtl/cordic_share_arbiter.sv
// cordic_share_arbiter: round-robin sharing of one iterative CORDIC core between two requesters,
// with a watchdog on core_done and a valid/ready response path back to the winner.
module cordic_share_arbiter #(
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    req_valid,
   output logic [1:0]    req_ready,
   input  logic [DW-1:0] req_angle0,
   input  logic [DW-1:0] req_angle1,
   input  logic [1:0]    req_cos,
   output logic [1:0]    resp_valid,
   input  logic [1:0]    resp_ready,
   output logic [DW-1:0] resp_data,
   output logic          resp_err,
   output logic          core_start,
   output logic [DW-1:0] core_angle,
   output logic          core_cos,
   output logic          core_abort,
   input  logic          core_done,
   input  logic [DW-1:0] core_result,
   output logic          busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
   state_t state, state_nxt;
   logic id, rr_last, gnt, take, hit;
   logic [7:0] cnt;
   // with both requesting, the one not served last wins
   assign gnt  = (req_valid == 2'b11) ? ~rr_last : req_valid[1];
   assign take = (state == IDLE) && (|req_valid);
   assign hit  = (state == WAIT) && (core_done || cnt == LAST);
   assign busy = (state != IDLE);
   always_comb begin
      state_nxt  = state;
      req_ready  = 2'b00;
      resp_valid = 2'b00;
      core_start = 1'b0;
      core_abort = 1'b0;
      case (state)
         IDLE: begin
            req_ready = (take && rst_n) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
            state_nxt = take ? ISSUE : IDLE;
         end
         ISSUE: begin
            core_start = 1'b1;
            state_nxt  = WAIT;
         end
         WAIT: begin
            core_abort = hit && !core_done;
            state_nxt  = hit ? RESP : WAIT;
         end
         default: begin
            resp_valid = id ? 2'b10 : 2'b01;
            state_nxt  = resp_ready[id] ? IDLE : RESP;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_angle <= '0;
         core_cos   <= 1'b0;
         id         <= 1'b0;
         rr_last    <= 1'b1;
         cnt        <= 8'd0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (take) begin
            core_angle <= gnt ? req_angle1 : req_angle0;
            core_cos   <= req_cos[gnt];
            id         <= gnt;
         end
         cnt <= (state == WAIT) ? cnt + 8'd1 : 8'd0;
         if (hit) begin
            resp_data <= core_done ? core_result : '0;
            resp_err  <= ~core_done;
         end
         if (state == RESP && resp_ready[id]) rr_last <= id;
      end
   end
endmodule

// File: tb/tb_cordic_share_arbiter.sv
// tb_cordic_share_arbiter: randomized checks of the CORDIC share arbiter against a
// transaction-level model of grants, latency, watchdog and response routing.
module tb_cordic_share_arbiter;
   localparam int DW = 32;
   localparam int TO = 16;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [1:0] req_valid = 2'b00, req_ready, req_cos = 2'b00;
   logic [1:0] resp_valid, resp_ready = 2'b00;
   logic [DW-1:0] req_angle0 = '0, req_angle1 = '0, resp_data, core_angle, core_result = '0;
   logic resp_err, core_start, core_cos, core_abort, core_done = 1'b0, busy;
   int chk_cnt = 0, pass_cnt = 0;
   int core_lat = 0, rem = 0;
   logic [DW-1:0] core_res = '0;
   bit stray = 0;
   bit last = 1;

   cordic_share_arbiter #(.DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_angle0(req_angle0), .req_angle1(req_angle1), .req_cos(req_cos),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_err(resp_err), .core_start(core_start), .core_angle(core_angle),
      .core_cos(core_cos), .core_abort(core_abort), .core_done(core_done),
      .core_result(core_result), .busy(busy)
   );

   always #5 clk = ~clk;

   // core model: done arrives core_lat cycles after the start cycle (0 = never)
   always @(posedge clk) begin
      bit fire;
      #2;
      fire = 0;
      if (!rst_n) rem = 0;
      else if (core_start) rem = core_lat;
      else if (rem > 0) begin
         rem--;
         fire = (rem == 0);
      end
      core_done = fire | stray;
      core_result = fire ? core_res : $urandom;
   end

   task automatic do_op(input logic [1:0] vm, input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                        input logic [1:0] cs, input int n, input logic [DW-1:0] res, input int hold);
      logic w, to;
      logic [1:0] own;
      logic [DW-1:0] exp_d;
      int exp_rc, rc, aborts, abort_cyc, bad;
      w = (vm == 2'b11) ? ~last : vm[1];
      own = w ? 2'b10 : 2'b01;
      to = !(n >= 1 && n <= TO);
      exp_rc = to ? TO + 2 : n + 2;
      exp_d = to ? '0 : res;
      @(negedge clk);
      req_valid = vm; req_angle0 = a0; req_angle1 = a1; req_cos = cs;
      core_lat = n; core_res = res;
      #1;
      chk_cnt++;
      if (req_ready !== own) $display("FAIL grant: req_ready=%b want %b", req_ready, own);
      else pass_cnt++;
      @(negedge clk);
      req_valid = 2'b00;
      chk_cnt++;
      if ({core_start, core_angle, core_cos, busy, req_ready} !== {1'b1, (w ? a1 : a0), cs[w], 1'b1, 2'b00})
         $display("FAIL issue: start=%b angle=%h cos=%b busy=%b rdy=%b want 1 %h %b 1 00",
                  core_start, core_angle, core_cos, busy, req_ready, (w ? a1 : a0), cs[w]);
      else pass_cnt++;
      rc = -1; aborts = 0; abort_cyc = -1;
      for (int c = 2; c < 80 && rc < 0; c++) begin
         @(negedge clk);
         if (core_abort) begin aborts++; abort_cyc = c; end
         if (resp_valid != 2'b00) rc = c;
      end
      chk_cnt++;
      if (rc !== exp_rc) $display("FAIL resp_latency: cycle %0d want %0d", rc, exp_rc);
      else pass_cnt++;
      chk_cnt++;
      if ({resp_valid, resp_data, resp_err} !== {own, exp_d, to})
         $display("FAIL resp: valid=%b data=%h err=%b want %b %h %b", resp_valid, resp_data, resp_err, own, exp_d, to);
      else pass_cnt++;
      chk_cnt++;
      if (aborts !== (to ? 1 : 0) || abort_cyc !== (to ? TO + 1 : -1))
         $display("FAIL abort: count=%0d cycle=%0d want %0d %0d", aborts, abort_cyc, to ? 1 : 0, to ? TO + 1 : -1);
      else pass_cnt++;
      bad = 0;
      for (int i = 0; i < hold; i++) begin
         resp_ready = ~own; req_valid = 2'b11; stray = (i == 1);
         @(negedge clk);
         if (resp_valid !== own || resp_data !== exp_d || resp_err !== to || req_ready !== 2'b00 || core_abort !== 1'b0)
            bad++;
      end
      stray = 0;
      chk_cnt++;
      if (bad !== 0) $display("FAIL backpressure_hold: %0d unstable cycles want 0", bad);
      else pass_cnt++;
      req_valid = 2'b00; resp_ready = own;
      @(negedge clk);
      resp_ready = 2'b00;
      chk_cnt++;
      if ({resp_valid, busy} !== 3'b000) $display("FAIL release: valid=%b busy=%b want 00 0", resp_valid, busy);
      else pass_cnt++;
      last = w;
   endtask

   task automatic test_reset;
      req_valid = 2'b11;
      #3;
      chk_cnt++;
      if ({req_ready, resp_valid, resp_data, resp_err, core_start, core_angle, core_cos, core_abort, busy} !== '0)
         $display("FAIL reset_outputs: rdy=%b rv=%b busy=%b want all 0", req_ready, resp_valid, busy);
      else pass_cnt++;
      @(negedge clk); @(negedge clk);
      req_valid = 2'b00;
      rst_n = 1'b1;
      last = 1;
   endtask

   task automatic test_contention;
      for (int k = 0; k < 4; k++)
         do_op(2'b11, $urandom, $urandom, 2'($urandom), int'($urandom_range(1, 6)), $urandom, 0);
   endtask

   task automatic test_single;
      do_op(2'b01, 32'h0000_4000, $urandom, 2'b01, 10, 32'h1234_5678, 0);
   endtask

   task automatic test_timeout;
      do_op(2'b10, $urandom, $urandom, 2'b00, 0, $urandom, 0);
      do_op(2'b11, $urandom, $urandom, 2'b11, 3, $urandom, 0);
   endtask

   task automatic test_backpressure;
      do_op(2'b01, $urandom, $urandom, 2'b10, 5, $urandom, 20);
   endtask

   task automatic test_boundary;
      do_op(2'b10, $urandom, $urandom, 2'b10, TO, $urandom, 0);
      do_op(2'b01, $urandom, $urandom, 2'b01, TO + 1, $urandom, 0);
      do_op(2'b11, $urandom, $urandom, 2'b01, 1, $urandom, 0);
   endtask

   task automatic test_random;
      for (int k = 0; k < 10; k++)
         do_op(2'($urandom_range(1, 3)), $urandom, $urandom, 2'($urandom),
               int'($urandom_range(0, TO + 4)), $urandom, int'($urandom_range(0, 3)));
   endtask

   task automatic test_async_reset;
      @(negedge clk);
      req_valid = 2'b01; req_angle0 = $urandom | 32'h1; req_cos = 2'b01; core_lat = 0;
      @(negedge clk);
      req_valid = 2'b00;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if ({busy, resp_valid, core_angle != '0} !== 4'b1001)
         $display("FAIL pre_reset_wait: busy=%b rv=%b angle=%h want busy 1 rv 00 nonzero angle", busy, resp_valid, core_angle);
      else pass_cnt++;
      #2;
      rst_n = 1'b0; req_valid = 2'b11;
      #1;
      chk_cnt++;
      if ({req_ready, resp_valid, resp_data, resp_err, core_start, core_angle, core_cos, core_abort, busy} !== '0)
         $display("FAIL async_reset: rdy=%b rv=%b data=%h angle=%h busy=%b want all 0",
                  req_ready, resp_valid, resp_data, core_angle, busy);
      else pass_cnt++;
      @(negedge clk); @(negedge clk);
      req_valid = 2'b00;
      #2 rst_n = 1'b1;
      last = 1;
      do_op(2'b11, $urandom, $urandom, 2'($urandom), 4, $urandom, 0);
   endtask

   initial begin
      test_reset;
      test_contention;
      test_single;
      test_timeout;
      test_backpressure;
      test_boundary;
      test_random;
      test_async_reset;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/cordic_share_arbiter.md
Name: cordic_share_arbiter

Overview:
- Shares one iterative CORDIC trig core between two requesters: requester 0 is the TinyQV bus-side register front end, requester 1 is a secondary engine such as a DMA or waveform sequencer.
- Accepts one operation at a time, arbitrates round-robin, and issues a single-cycle start pulse to the core.
- Waits for the core's done signal, with a watchdog timeout, then routes the result back to the winning requester over a valid/ready handshake.
- Sits between the peripheral register decode and the CORDIC instruction core.

Parameters:
- DW, 32, operand/result width.
- TIMEOUT, 64, maximum cycles to wait for core_done after start. Legal range 2..255.

Ports:
- clk  in  1  project clock (nominally 64 MHz)
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; a request transfers on valid&ready
- req_angle0  in  DW  requester 0 operand
- req_angle1  in  DW  requester 1 operand
- req_cos  in  2  per-requester function select (1=cos, 0=sin)
- resp_valid  out  2  per-requester response valid
- resp_ready  in  2  per-requester response accept
- resp_data  out  DW  response result, shared by both requesters and qualified by resp_valid
- resp_err  out  1  response is a timeout error, qualified by resp_valid
- core_start  out  1  one-cycle start pulse to the CORDIC core
- core_angle  out  DW  operand to the core
- core_cos  out  1  function select to the core
- core_abort  out  1  one-cycle pulse; the core must return to idle
- core_done  in  1  core result valid, one-cycle pulse
- core_result  in  DW  core result, valid when core_done=1
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; state=IDLE; latched operand, function select and id=0; rr_last=1, so requester 0 wins first.
- Reset is asynchronous and takes effect mid-operation. It aborts any transaction silently: no response, no core_abort. The core is reset by the same rst_n.

State IDLE:
- If exactly one req_valid is high, grant that requester.
- If both are high, grant the requester other than rr_last.
- req_ready[grant] is combinationally 1 in IDLE only; the other bit is 0.
- On transfer, latch operand, cos and id, then go to ISSUE.
- req_ready is 0 in all other states.

State ISSUE:
- core_start=1 for exactly this cycle.
- core_angle and core_cos drive the latched values. They stay stable from ISSUE until the next request transfer, not just during ISSUE.
- Clear the watchdog counter (8 bits) to 0, then go to WAIT.

State WAIT:
- core_done is sampled only in this state. A done seen in ISSUE, RESP or IDLE is ignored.
- On core_done: latch core_result into resp_data, set resp_err=0, go to RESP.
- Otherwise the counter increments each cycle.
- When the counter equals TIMEOUT-1 with no done: core_abort=1 for that cycle, resp_data=0, resp_err=1, go to RESP.
- If core_done and the timeout hit coincide, done wins: normal result, no abort.

State RESP:
- resp_valid[id]=1; the other bit stays 0. resp_data and resp_err are held stable.
- On resp_ready[id]=1: set rr_last=id, drop resp_valid next cycle, go to IDLE.
- resp_ready of the non-owner is ignored.

Timing:
- Minimum latency, request transfer to resp_valid: 2 + N cycles, where N is core cycles from start to done (N>=1).
- Earliest next request acceptance: the cycle after the response handshake.
- Throughput: one operation in flight; no queueing.
- A requester may drop req_valid before acceptance without side effects.
- resp_data and resp_err are undefined-but-stable outside RESP; implement as hold-last-value.

Test Plan:
- Single op: req_valid=01, angle0=0x0000_4000, cos=1; core model returns 0x1234_5678 after 10 cycles. Require req_ready[0] in cycle 0, core_start in cycle 1, resp_valid=01 with data 0x1234_5678 and err=0 in cycle 12; IDLE after resp_ready.
- Contention after reset: req_valid=11 held. Grants alternate 0,1,0,1 over 4 ops, each issuing its own angle to core_angle.
- Timeout, TIMEOUT=8, core never asserts done: core_abort pulses exactly once 8 cycles after core_start. Requester receives resp_err=1, data=0, and the next request proceeds normally.
- Backpressure: resp_ready held 0 for 20 cycles. resp_valid and data stay stable, req_ready stays 0 even with req_valid[1]=1, and a stray core_done pulse is ignored.
- Boundary: core_done on the same cycle the counter hits TIMEOUT-1. Normal result, core_abort=0.
- Async reset asserted mid-WAIT: all outputs 0 immediately, with no clock edge required. After release, requester 0 wins a simultaneous request.
